layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Sequences one fully-connected layer of the MNIST classifier. On each start it clears the neuron accumulators, then streams every input activation from the input buffer to all neurons in parallel, with a shared address that also indexes the weight memories. It waits for the MAC and ReLU pipelines to drain, captures the parallel activation vector, and serializes it to the next layer or the argmax stage over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 16, width of one activation word (Q1.x fixed point, as produced by the activation stage)
- `NUM_INPUTS`, 784, input activations per inference
- `NUM_NEURONS`, 30, neurons in the layer
- `MAC_LATENCY`, 2, cycles from a neuron input word to its accumulator update; must be ≥1
- `ADDR_WIDTH`, $clog2(NUM_INPUTS), input/weight address width
- `IDX_WIDTH`, $clog2(NUM_NEURONS), output index width
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `i_start`  in  1  start one layer pass; sampled only in IDLE
- `o_busy`  out  1  high in every state except IDLE
- `o_done`  out  1  one-cycle pulse after the last output handshake
- `o_in_rd_en`  out  1  input-buffer and weight-memory read enable; read latency is fixed at 1 cycle
- `o_in_addr`  out  ADDR_WIDTH  input and weight address
- `i_in_data`  in  DATA_WIDTH  input-buffer read data, valid 1 cycle after `o_in_rd_en`
- `o_neuron_clear`  out  1  one-cycle accumulator clear to all neurons
- `o_neuron_valid`  out  1  `o_in_rd_en` delayed 1 cycle
- `o_neuron_data`  out  DATA_WIDTH  `i_in_data` passed through combinationally
- `i_act_data`  in  NUM_NEURONS*DATA_WIDTH  registered ReLU outputs; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- `o_out_valid`  out  1  output word valid
- `o_out_data`  out  DATA_WIDTH  activation of neuron `o_out_idx`
- `o_out_idx`  out  IDX_WIDTH  neuron index of the current word
- `i_out_ready`  in  1  downstream ready

## Operation
- **FSM states:** IDLE → CLEAR → LOAD → DRAIN → CAPTURE → OUT → DONE → IDLE.
- **IDLE:** if `i_start` is high, go to CLEAR.
- **CLEAR:** lasts 1 cycle with `o_neuron_clear`=1, then LOAD.
- **LOAD:** lasts NUM_INPUTS cycles. `o_in_rd_en`=1 and `o_in_addr` counts 0..NUM_INPUTS-1, one step per cycle with no gaps. After the last address, go to DRAIN.
- **DRAIN:** lasts MAC_LATENCY+2 cycles, counted down from the first DRAIN cycle. This covers the memory read, the MAC and the ReLU register. Then go to CAPTURE.
- **CAPTURE:** lasts 1 cycle and latches `i_act_data` into an internal capture register. Later changes on `i_act_data` have no effect until the next pass.
- **OUT:** `o_out_valid`=1 with `o_out_idx` starting at 0. On `o_out_valid & i_out_ready`, the index increments. On the handshake at index NUM_NEURONS-1, go to DONE.
- **DONE:** `o_done`=1 for 1 cycle, then IDLE.
- **Ignored start:** `i_start` is ignored in every state except IDLE. A held `i_start` in IDLE starts back-to-back passes, with DONE→IDLE→CLEAR.
- **Address hold:** `o_in_addr` holds its last value outside LOAD; only `o_in_rd_en` qualifies it.
- **Backpressure:** while `o_out_valid & !i_out_ready`, `o_out_data` and `o_out_idx` stay stable. There is no timeout.
- **Reset:** asserting `reset_n` low at any point aborts the pass immediately. The FSM goes to IDLE, all counters clear, and the capture register clears.
- **Reset values:** every output is 0 during and after reset.

## Timing
Cycle 0 is the cycle in which `i_start` is sampled in IDLE.
- **CLEAR:** cycle 1.
- **LOAD:** cycles 2..NUM_INPUTS+1. Neuron valid is high on cycles 3..NUM_INPUTS+2.
- **DRAIN:** cycles NUM_INPUTS+2..NUM_INPUTS+MAC_LATENCY+3.
- **CAPTURE:** cycle NUM_INPUTS+MAC_LATENCY+4.
- **First output valid:** cycle NUM_INPUTS+MAC_LATENCY+5.
- **Total latency with `i_out_ready` tied high:** start to `o_done` is NUM_INPUTS+MAC_LATENCY+NUM_NEURONS+5 cycles.
- **Combinational paths:** none from `i_out_ready` to any output. `o_neuron_data` is the only input-to-output combinational path.

## Structure
- **Package `nn_pkg`:** holds the FSM state enum `seq_state_t` and the shared `DATA_WIDTH` default. It also holds the ReLU Q-format constants, so the sequencer and the activation stage agree on them.
- **Sub-module `act_serializer`:** contains the capture register, the index counter, the output mux and the valid/ready logic. It has ports load, start, done_last.
- **`layer_sequencer`:** keeps the FSM and the LOAD/DRAIN counters.

## Test plan
Test parameters are NUM_INPUTS=4, NUM_NEURONS=3, MAC_LATENCY=2.
- **Nominal pass:** start at cycle 0 with ready tied high. Required response:
  - clear at cycle 1;
  - rd_en on cycles 2-5 with addr 0,1,2,3;
  - neuron_valid on cycles 3-6;
  - capture at cycle 10;
  - outputs idx 0,1,2 on cycles 11-13;
  - `o_done` at cycle 14;
  - busy low at cycle 15.
- **Data mapping:** `i_act_data`={16'h0003,16'h0002,16'h7FFF}, i.e. neuron 2..0. Required outputs in order are 7FFF, 0002, 0003. Changing `i_act_data` after cycle 10 does not alter the outputs.
- **Backpressure:** hold ready low for cycles 11-15, then high. idx 0 stays stable on cycles 11-16. `o_done` moves to cycle 19.
- **Start while busy:** pulse `i_start` at cycles 3 and 12. There is no second clear and no extra rd_en, and the timing is identical to the nominal pass.
- **Reset mid-operation:** drop `reset_n` at cycle 4 (during LOAD). All outputs go to 0 asynchronously. After release, a new start gives the nominal timing from addr 0.
- **Back-to-back:** hold `i_start` high throughout. The second clear occurs exactly 2 cycles after the first `o_done`.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the MNIST fully-connected layer blocks.
package nn_pkg;

    localparam int NN_DATA_WIDTH = 16;

    // Activation words are Q1.15; ReLU saturates positive values to RELU_MAX.
    localparam int                         RELU_FRAC_BITS = 15;
    localparam logic [NN_DATA_WIDTH-1:0]   RELU_MAX       = 16'h7FFF;
    localparam logic [NN_DATA_WIDTH-1:0]   RELU_ZERO      = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Serialized activation stream from a layer to the next layer or argmax stage.
interface layer_sequencer_if #(
    parameter int DATA_WIDTH = nn_pkg::NN_DATA_WIDTH,
    parameter int IDX_WIDTH  = 5
);
    logic                  o_out_valid;
    logic [DATA_WIDTH-1:0] o_out_data;
    logic [IDX_WIDTH-1:0]  o_out_idx;
    logic                  i_out_ready;

    modport master (output o_out_valid, o_out_data, o_out_idx, input i_out_ready);
    modport slave  (input o_out_valid, o_out_data, o_out_idx, output i_out_ready);
endinterface

// File: rtl/act_serializer.sv
// Captures the parallel ReLU vector and streams it out one neuron per handshake.
module act_serializer
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH  = NN_DATA_WIDTH,
    parameter int NUM_NEURONS = 30,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              load,
    input  logic                              start,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] act_data,
    output logic                              done_last,
    layer_sequencer_if.master                 out_if
);

    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] cap;
    logic                                   valid;
    logic [IDX_WIDTH-1:0]                   idx;
    logic                                   fire;

    assign fire      = valid & out_if.i_out_ready;
    assign done_last = fire && (idx == IDX_WIDTH'(NUM_NEURONS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap   <= '0;
            valid <= 1'b0;
            idx   <= '0;
        end else begin
            if (load)
                cap <= act_data;
            if (start) begin
                valid <= 1'b1;
                idx   <= '0;
            end else if (fire) begin
                if (done_last)
                    valid <= 1'b0;
                else
                    idx <= idx + 1'b1;
            end
        end
    end

    // Data and index come straight from registers, so they hold under backpressure.
    assign out_if.o_out_valid = valid;
    assign out_if.o_out_idx   = idx;
    assign out_if.o_out_data  = cap[idx];

endmodule

// File: rtl/layer_sequencer.sv
// One fully-connected layer pass: clear, stream inputs, drain MAC/ReLU, serialize.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH  = NN_DATA_WIDTH,
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 30,
    parameter int MAC_LATENCY = 2,
    parameter int ADDR_WIDTH  = $clog2(NUM_INPUTS),
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_start,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_in_rd_en,
    output logic [ADDR_WIDTH-1:0]             o_in_addr,
    input  logic [DATA_WIDTH-1:0]             i_in_data,
    output logic                              o_neuron_clear,
    output logic                              o_neuron_valid,
    output logic [DATA_WIDTH-1:0]             o_neuron_data,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_act_data,
    layer_sequencer_if.master                 out_if
);

    // Memory read + MAC pipeline + ReLU register.
    localparam int DRAIN_CYCLES = MAC_LATENCY + 2;
    localparam int DCW          = $clog2(DRAIN_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);

    seq_state_t     state;
    logic [DCW-1:0] drain_cnt;
    logic           done_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_neuron_clear <= 1'b0;
            o_in_rd_en     <= 1'b0;
            o_in_addr      <= '0;
            drain_cnt      <= '0;
        end else begin
            o_done         <= 1'b0;
            o_neuron_clear <= 1'b0;
            case (state)
                S_IDLE: if (i_start) begin
                    state          <= S_CLEAR;
                    o_busy         <= 1'b1;
                    o_neuron_clear <= 1'b1;
                end
                S_CLEAR: begin
                    state      <= S_LOAD;
                    o_in_rd_en <= 1'b1;
                    o_in_addr  <= '0;
                end
                S_LOAD: begin
                    if (o_in_addr == LAST_ADDR) begin
                        state      <= S_DRAIN;
                        o_in_rd_en <= 1'b0;
                        drain_cnt  <= DCW'(DRAIN_CYCLES - 1);
                    end else begin
                        o_in_addr <= o_in_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0)
                        state <= S_CAPTURE;
                    else
                        drain_cnt <= drain_cnt - 1'b1;
                end
                S_CAPTURE: state <= S_OUT;
                S_OUT: if (done_last) begin
                    state  <= S_DONE;
                    o_done <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            o_neuron_valid <= 1'b0;
        else
            o_neuron_valid <= o_in_rd_en;
    end

    // Gated by valid so the neuron bus reads zero whenever no word is in flight.
    assign o_neuron_data = o_neuron_valid ? i_in_data : '0;

    act_serializer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (state == S_CAPTURE),
        .start     (state == S_CAPTURE),
        .act_data  (i_act_data),
        .done_last (done_last),
        .out_if    (out_if)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with NUM_INPUTS=4, NUM_NEURONS=3, MAC_LATENCY=2.
module tb_layer_sequencer;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int ML = 2;
    localparam int AW = 2;
    localparam int IW = 2;

    localparam logic [NN*DW-1:0] ACT     = {16'h0003, 16'h0002, 16'h7FFF};
    localparam logic [NN*DW-1:0] GARBAGE = {16'h1111, 16'h2222, 16'h3333};

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_start = 1'b0;
    logic              o_busy, o_done, o_in_rd_en, o_neuron_clear, o_neuron_valid;
    logic [AW-1:0]     o_in_addr;
    logic [DW-1:0]     i_in_data;
    logic [DW-1:0]     o_neuron_data;
    logic [NN*DW-1:0]  i_act_data;

    layer_sequencer_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) oif ();

    layer_sequencer #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .MAC_LATENCY(ML),
        .ADDR_WIDTH(AW), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_in_rd_en(o_in_rd_en), .o_in_addr(o_in_addr), .i_in_data(i_in_data),
        .o_neuron_clear(o_neuron_clear), .o_neuron_valid(o_neuron_valid),
        .o_neuron_data(o_neuron_data), .i_act_data(i_act_data), .out_if(oif)
    );

    always #5 clk = ~clk;

    // Input buffer model: 1-cycle read latency, word = 0x1000 + address.
    always @(posedge clk) i_in_data <= o_in_rd_en ? (16'h1000 + 16'(o_in_addr)) : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int val; } ev_t;
    ev_t q_clr[$], q_rd[$], q_nv[$], q_out[$], q_done[$];
    logic [DW-1:0] exp_act [NN] = '{16'h7FFF, 16'h0002, 16'h0003};

    int n_chk = 0, n_err = 0, t0 = 0;
    bit mon_en = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic unexp(string nm, int rel);
        n_chk++;
        n_err++;
        $display("FAIL unexpected_%s: got event at cycle %0d, expected none", nm, rel);
    endtask

    // Monitor: pops expected events whenever the DUT presents one.
    int            m_rel;
    ev_t           m_e;
    bit            stall_prev = 1'b0;
    logic [IW-1:0] prev_idx;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            m_rel = cyc - t0;
            if (o_neuron_clear) begin
                if (q_clr.size() == 0) unexp("clear", m_rel);
                else begin m_e = q_clr.pop_front(); chk("clear_cycle", 64'(m_rel), 64'(m_e.cyc)); end
            end
            if (o_in_rd_en) begin
                if (q_rd.size() == 0) unexp("rd_en", m_rel);
                else begin
                    m_e = q_rd.pop_front();
                    chk("rd_cycle", 64'(m_rel), 64'(m_e.cyc));
                    chk("rd_addr", 64'(o_in_addr), 64'(m_e.val));
                end
            end
            if (o_neuron_valid) begin
                if (q_nv.size() == 0) unexp("neuron_valid", m_rel);
                else begin
                    m_e = q_nv.pop_front();
                    chk("nv_cycle", 64'(m_rel), 64'(m_e.cyc));
                    chk("nv_data", 64'(o_neuron_data), 64'(m_e.val));
                end
            end
            if (oif.o_out_valid && oif.i_out_ready) begin
                if (q_out.size() == 0) unexp("out", m_rel);
                else begin
                    m_e = q_out.pop_front();
                    chk("out_cycle", 64'(m_rel), 64'(m_e.cyc));
                    chk("out_data", 64'(oif.o_out_data), 64'(exp_act[m_e.val]));
                    chk("out_idx", 64'(oif.o_out_idx), 64'(m_e.val));
                end
            end
            if (o_done) begin
                if (q_done.size() == 0) unexp("done", m_rel);
                else begin m_e = q_done.pop_front(); chk("done_cycle", 64'(m_rel), 64'(m_e.cyc)); end
            end
            if (stall_prev) begin
                chk("bp_idx_stable", 64'(oif.o_out_idx), 64'(prev_idx));
                chk("bp_data_stable", 64'(oif.o_out_data), 64'(prev_data));
            end
            stall_prev = oif.o_out_valid && !oif.i_out_ready;
            prev_idx   = oif.o_out_idx;
            prev_data  = oif.o_out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rel(int r);
        while (cyc - t0 < r) step();
    endtask

    // Expected events of one pass starting at relative cycle base.
    task automatic push_pass(int base, int first_out);
        q_clr.push_back('{base + 1, 0});
        for (int i = 0; i < NI; i++) begin
            q_rd.push_back('{base + 2 + i, i});
            q_nv.push_back('{base + 3 + i, 16'h1000 + i});
        end
        for (int k = 0; k < NN; k++) q_out.push_back('{base + first_out + k, k});
        q_done.push_back('{base + first_out + NN, 0});
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic end_check(string nm);
        chk(nm, 64'(q_clr.size() + q_rd.size() + q_nv.size() + q_out.size() + q_done.size()), 64'd0);
        q_clr.delete(); q_rd.delete(); q_nv.delete(); q_out.delete(); q_done.delete();
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({o_busy, o_done, o_in_rd_en, o_in_addr, o_neuron_clear, o_neuron_valid,
                    o_neuron_data, oif.o_out_valid, oif.o_out_data, oif.o_out_idx});
    endfunction

    initial begin
        i_act_data      = ACT;
        oif.i_out_ready = 1'b1;

        step(); step();
        chk("reset_outputs_during", all_outs(), 64'd0);
        reset_n = 1'b1;
        step(); step();
        chk("reset_outputs_after", all_outs(), 64'd0);
        mon_en = 1'b1;

        // Nominal pass; ACT only presented in the capture cycle.
        i_act_data = GARBAGE;
        t0 = cyc;
        push_pass(0, 11);
        chk("busy_c0", 64'(o_busy), 64'd0);
        start_pulse();
        chk("busy_c1", 64'(o_busy), 64'd1);
        goto_rel(10); i_act_data = ACT;
        goto_rel(11); i_act_data = GARBAGE;
        goto_rel(14); chk("busy_c14", 64'(o_busy), 64'd1);
        goto_rel(15); chk("busy_c15", 64'(o_busy), 64'd0);
        goto_rel(18);
        end_check("nominal_drained");

        // Backpressure: ready low on cycles 11..15.
        i_act_data = ACT;
        t0 = cyc;
        push_pass(0, 16);
        start_pulse();
        goto_rel(11); oif.i_out_ready = 1'b0; i_act_data = GARBAGE;
        goto_rel(16); oif.i_out_ready = 1'b1;
        goto_rel(22);
        end_check("backpressure_drained");

        // Start pulses while busy are ignored.
        i_act_data = ACT;
        t0 = cyc;
        push_pass(0, 11);
        start_pulse();
        goto_rel(3);  start_pulse();
        goto_rel(12); start_pulse();
        goto_rel(18);
        end_check("start_busy_drained");

        // Reset during LOAD, then a fresh nominal pass.
        t0 = cyc;
        q_clr.push_back('{1, 0});
        q_rd.push_back('{2, 0});
        q_rd.push_back('{3, 1});
        q_nv.push_back('{3, 16'h1000});
        start_pulse();
        goto_rel(4);
        #2 reset_n = 1'b0;
        #1 chk("reset_mid_outputs", all_outs(), 64'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        end_check("reset_partial_drained");
        t0 = cyc;
        push_pass(0, 11);
        start_pulse();
        goto_rel(18);
        end_check("post_reset_drained");

        // Held start: second clear 2 cycles after first done.
        t0 = cyc;
        push_pass(0, 11);
        push_pass(15, 11);
        i_start = 1'b1;
        goto_rel(17); i_start = 1'b0;
        goto_rel(33);
        end_check("b2b_drained");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
